// File: rtl/ecc_scrub_ctrl.sv
// SECDED scrub controller: counts CE/UE events and writes corrected words back to memory.
// Optional SCRUB_DEDUP_EN suppresses a CE whose address matches the newest pending write-back.
`timescale 1ns/1ps
module ecc_scrub_ctrl #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_valid,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [31:0]       corr_data,
  input  logic [5:0]        corr_parity,
  input  logic              single_error,
  input  logic              double_error,
  output logic              wb_req,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [31:0]       wb_data,
  output logic [6:0]        wb_parity,
  input  logic              wb_ack,
  input  logic              err_clr,
  output logic [CNT_W-1:0]  ce_count,
  output logic [CNT_W-1:0]  ue_count,
  output logic              ue_irq,
  output logic [ADDR_W-1:0] ue_addr,
  output logic              fifo_ovf,
  output logic              busy
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned EW = ADDR_W + 32 + 7;

  typedef enum logic [0:0] {StIdle, StReq} state_e;

  state_e state_q, state_d;

  logic is_ce, is_ue;
  assign is_ue = rd_valid & double_error;
  assign is_ce = rd_valid & single_error & ~double_error;

  // Capture stage: corrected word plus regenerated overall check bit.
  logic              cap_ce_q;
  logic [ADDR_W-1:0] cap_addr_q;
  logic [31:0]       cap_data_q;
  logic [6:0]        cap_par_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_ce_q   <= 1'b0;
      cap_addr_q <= '0;
      cap_data_q <= '0;
      cap_par_q  <= '0;
    end else begin
      cap_ce_q <= is_ce;
      if (is_ce) begin
        cap_addr_q <= rd_addr;
        cap_data_q <= corr_data;
        cap_par_q  <= {^{corr_data, corr_parity}, corr_parity};
      end
    end
  end

  // Write-back FIFO; the extra pointer bit separates full from empty.
  logic [EW-1:0] mem_q [DEPTH];
  logic [PW:0]   wr_ptr_q, rd_ptr_q;
  logic          empty, full, push, pop, drop, push_try, dup, ack_done;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);

  assign ack_done = (state_q == StReq) && wb_ack;
  assign push_try = cap_ce_q && !dup;
  assign push     = push_try && (!full || pop);
  assign drop     = push_try && full && !pop;

`ifdef SCRUB_DEDUP_EN
  logic              last_valid_q;
  logic [ADDR_W-1:0] last_addr_q;

  assign dup = last_valid_q && (cap_addr_q == last_addr_q);

  // With the FIFO empty, the entry being acknowledged is the newest one pushed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_valid_q <= 1'b0;
      last_addr_q  <= '0;
    end else if (push) begin
      last_valid_q <= 1'b1;
      last_addr_q  <= cap_addr_q;
    end else if (ack_done && empty) begin
      last_valid_q <= 1'b0;
    end
  end
`else
  assign dup = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[PW-1:0]] <= {cap_addr_q, cap_data_q, cap_par_q};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + (PW+1)'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + (PW+1)'(1);
    end
  end

  // Write-back FSM; the head leaves the FIFO when it is loaded onto wb_*.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      StIdle: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = StReq;
        end
      end
      StReq: begin
        if (wb_ack) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  logic [ADDR_W-1:0] wb_addr_q;
  logic [31:0]       wb_data_q;
  logic [6:0]        wb_par_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      wb_addr_q <= '0;
      wb_data_q <= '0;
      wb_par_q  <= '0;
    end else begin
      state_q <= state_d;
      if (pop) {wb_addr_q, wb_data_q, wb_par_q} <= mem_q[rd_ptr_q[PW-1:0]];
    end
  end

  // Status: a same-cycle clear is applied first, then the event on top of it.
  logic [CNT_W-1:0]  ce_q, ue_q, ce_base, ue_base, ce_d, ue_d;
  logic              irq_q, irq_base, irq_d, ovf_q, ovf_d;
  logic [ADDR_W-1:0] ue_addr_q, ue_addr_base, ue_addr_d;

  always_comb begin
    ce_base      = err_clr ? '0 : ce_q;
    ue_base      = err_clr ? '0 : ue_q;
    irq_base     = err_clr ? 1'b0 : irq_q;
    ue_addr_base = err_clr ? '0 : ue_addr_q;
    ce_d         = (is_ce && ce_base != '1) ? ce_base + CNT_W'(1) : ce_base;
    ue_d         = (is_ue && ue_base != '1) ? ue_base + CNT_W'(1) : ue_base;
    irq_d        = irq_base | is_ue;
    ue_addr_d    = (is_ue && !irq_base) ? rd_addr : ue_addr_base;
    ovf_d        = (err_clr ? 1'b0 : ovf_q) | drop;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ce_q      <= '0;
      ue_q      <= '0;
      irq_q     <= 1'b0;
      ue_addr_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      ce_q      <= ce_d;
      ue_q      <= ue_d;
      irq_q     <= irq_d;
      ue_addr_q <= ue_addr_d;
      ovf_q     <= ovf_d;
    end
  end

  assign wb_req    = (state_q == StReq);
  assign wb_addr   = wb_addr_q;
  assign wb_data   = wb_data_q;
  assign wb_parity = wb_par_q;
  assign ce_count  = ce_q;
  assign ue_count  = ue_q;
  assign ue_irq    = irq_q;
  assign ue_addr   = ue_addr_q;
  assign fifo_ovf  = ovf_q;
  assign busy      = !empty || (state_q == StReq) || cap_ce_q;

endmodule

// File: tb/tb_ecc_scrub_ctrl.sv
// Directed self-checking bench for ecc_scrub_ctrl (DEPTH=4, ADDR_W=10, CNT_W=16).
`timescale 1ns/1ps
module tb_ecc_scrub_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_valid, single_error, double_error, wb_ack, err_clr;
  logic [9:0]  rd_addr;
  logic [31:0] corr_data;
  logic [5:0]  corr_parity;
  logic        wb_req, ue_irq, fifo_ovf, busy;
  logic [9:0]  wb_addr, ue_addr;
  logic [31:0] wb_data;
  logic [6:0]  wb_parity;
  logic [15:0] ce_count, ue_count;

  int checks = 0;
  int errors = 0;

  ecc_scrub_ctrl #(.ADDR_W(10), .DEPTH(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .rd_valid(rd_valid), .rd_addr(rd_addr), .corr_data(corr_data),
    .corr_parity(corr_parity), .single_error(single_error), .double_error(double_error),
    .wb_req(wb_req), .wb_addr(wb_addr), .wb_data(wb_data), .wb_parity(wb_parity),
    .wb_ack(wb_ack), .err_clr(err_clr), .ce_count(ce_count), .ue_count(ue_count),
    .ue_irq(ue_irq), .ue_addr(ue_addr), .fifo_ovf(fifo_ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, errors %0d", errors);
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [9:0] a, input logic [31:0] d,
                       input logic [5:0] p, input logic se, input logic de);
    rd_valid = v; rd_addr = a; corr_data = d; corr_parity = p;
    single_error = se; double_error = de;
  endtask

  task automatic clear_status;
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (wb_req) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic ack_one;
    wb_ack = 1'b1;
    tick();
    wb_ack = 1'b0;
  endtask

  task automatic drain;
    for (int i = 0; i < 30; i++) begin
      if (wb_req) ack_one();
      else tick();
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    wb_ack = 1'b0; err_clr = 1'b0;
    drive(0, '0, '0, '0, 0, 0);
    #3;
    checks++; if (wb_req !== 1'b0) begin errors++; $display("FAIL reset_wb_req: got %b want 0", wb_req); end
    checks++; if ({wb_addr, wb_data, wb_parity} !== '0) begin errors++; $display("FAIL reset_wb_bus: got %h want 0", {wb_addr, wb_data, wb_parity}); end
    checks++; if ({ce_count, ue_count} !== 32'h0) begin errors++; $display("FAIL reset_counts: got %h want 0", {ce_count, ue_count}); end
    checks++; if ({ue_irq, ue_addr, fifo_ovf, busy} !== '0) begin errors++; $display("FAIL reset_flags: got %h want 0", {ue_irq, ue_addr, fifo_ovf, busy}); end
    tick();
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_ce_writeback;
    clear_status();
    drive(1, 10'h010, 32'h1, 6'h3, 1, 0);
    tick();                                         // edge N
    drive(0, '0, '0, '0, 0, 0);
    checks++; if (ce_count !== 16'd1) begin errors++; $display("FAIL ce_count_one: got %0d want 1", ce_count); end
    tick();                                         // edge N+1
    checks++; if (wb_req !== 1'b0) begin errors++; $display("FAIL ce_req_early: got %b want 0", wb_req); end
    tick();                                         // edge N+2
    checks++; if (wb_req !== 1'b1) begin errors++; $display("FAIL ce_req_latency: got %b want 1", wb_req); end
    checks++; if (wb_addr !== 10'h010 || wb_data !== 32'h1) begin errors++; $display("FAIL ce_wb_word: got %h/%h want 010/00000001", wb_addr, wb_data); end
    checks++; if (wb_parity !== 7'b1000011) begin errors++; $display("FAIL ce_wb_parity: got %b want 1000011", wb_parity); end
    tick();
    checks++; if (wb_req !== 1'b1 || wb_addr !== 10'h010) begin errors++; $display("FAIL ce_req_hold: got %b/%h want 1/010", wb_req, wb_addr); end
    ack_one();
    checks++; if (wb_req !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL ce_done: got req %b busy %b want 0 0", wb_req, busy); end
  endtask

  task automatic test_ue_capture;
    bit saw_req = 1'b0;
    clear_status();
    drive(1, 10'h020, 32'hDEAD, 6'h1, 0, 1);
    tick();
    drive(1, 10'h030, 32'hBEEF, 6'h2, 1, 1);
    tick();
    drive(0, 10'h040, 32'h0, 6'h0, 1, 1);           // ignored: rd_valid low
    tick();
    drive(0, '0, '0, '0, 0, 0);
    checks++; if (ue_count !== 16'd2 || ce_count !== 16'd0) begin errors++; $display("FAIL ue_counts: got ue %0d ce %0d want 2 0", ue_count, ce_count); end
    checks++; if (ue_irq !== 1'b1 || ue_addr !== 10'h020) begin errors++; $display("FAIL ue_irq_addr: got %b/%h want 1/020", ue_irq, ue_addr); end
    for (int i = 0; i < 5; i++) begin
      if (wb_req || busy) saw_req = 1'b1;
      tick();
    end
    checks++; if (saw_req !== 1'b0) begin errors++; $display("FAIL ue_no_wb: got %b want 0", saw_req); end
    clear_status();
    checks++; if ({ue_count, ue_irq, ue_addr, ce_count} !== '0) begin errors++; $display("FAIL ue_clear: got %h want 0", {ue_count, ue_irq, ue_addr, ce_count}); end
  endtask

  task automatic test_clr_priority;
    clear_status();
    drive(1, 10'h060, 32'h0, 6'h0, 0, 1);
    tick();
    drive(1, 10'h050, 32'h7, 6'h0, 1, 0);
    tick();
    drive(1, 10'h070, 32'h0, 6'h0, 0, 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    drive(0, '0, '0, '0, 0, 0);
    checks++; if (ue_count !== 16'd1 || ue_addr !== 10'h070 || ue_irq !== 1'b1) begin errors++; $display("FAIL clr_ue_event: got %0d/%h/%b want 1/070/1", ue_count, ue_addr, ue_irq); end
    checks++; if (ce_count !== 16'd0) begin errors++; $display("FAIL clr_ce_cleared: got %0d want 0", ce_count); end
    drive(1, 10'h051, 32'h3, 6'h0, 1, 0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    drive(0, '0, '0, '0, 0, 0);
    checks++; if (ce_count !== 16'd1 || ue_count !== 16'd0 || ue_irq !== 1'b0) begin errors++; $display("FAIL clr_ce_event: got ce %0d ue %0d irq %b want 1 0 0", ce_count, ue_count, ue_irq); end
    drain();
  endtask

  task automatic test_parity;
    bit ok;
    clear_status();
    drive(1, 10'h011, 32'h2, 6'h5, 1, 0);
    tick();
    drive(0, '0, '0, '0, 0, 0);
    wait_req(ok);
    checks++; if (!ok || wb_parity !== 7'h45) begin errors++; $display("FAIL parity_45: got req %b parity %h want 1 45", ok, wb_parity); end
    ack_one();
    drive(1, 10'h3FF, 32'h0, 6'h0, 1, 0);
    tick();
    drive(0, '0, '0, '0, 0, 0);
    wait_req(ok);
    checks++; if (!ok || wb_parity !== 7'h00 || wb_addr !== 10'h3FF) begin errors++; $display("FAIL parity_00: got req %b parity %h addr %h want 1 00 3ff", ok, wb_parity, wb_addr); end
    ack_one();
    drain();
  endtask

  task automatic test_overflow;
    bit ok;
    bit extra = 1'b0;
    clear_status();
    wb_ack = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive(1, 10'h100 + 10'(i), 32'hA0 + 32'(i), 6'h0, 1, 0);
      tick();
    end
    drive(0, '0, '0, '0, 0, 0);
    tick();
    tick();
    checks++; if (fifo_ovf !== 1'b1 || ce_count !== 16'd6) begin errors++; $display("FAIL ovf_flag: got ovf %b ce %0d want 1 6", fifo_ovf, ce_count); end
    for (int k = 0; k < 5; k++) begin
      wait_req(ok);
      checks++;
      if (!ok || wb_addr !== 10'h100 + 10'(k) || wb_data !== 32'hA0 + 32'(k)) begin
        errors++;
        $display("FAIL ovf_drain_%0d: got req %b %h/%h want 1 %h/%h", k, ok, wb_addr, wb_data,
                 10'h100 + 10'(k), 32'hA0 + 32'(k));
      end
      ack_one();
    end
    for (int i = 0; i < 6; i++) begin
      if (wb_req) extra = 1'b1;
      tick();
    end
    checks++; if (extra !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL ovf_sixth_dropped: got extra %b busy %b want 0 0", extra, busy); end
    clear_status();
    checks++; if (fifo_ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b want 0", fifo_ovf); end
  endtask

  task automatic test_reset_mid_req;
    bit saw = 1'b0;
    clear_status();
    wb_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1, 10'h200 + 10'(i), 32'h55 + 32'(i), 6'h0, 1, 0);
      tick();
    end
    drive(0, '0, '0, '0, 0, 0);
    tick();                                         // first in flight, two queued
    checks++; if (wb_req !== 1'b1 || wb_addr !== 10'h200) begin errors++; $display("FAIL rst_pre_req: got %b/%h want 1/200", wb_req, wb_addr); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (wb_req !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rst_async_req: got req %b busy %b want 0 0", wb_req, busy); end
    checks++; if ({wb_addr, wb_data, wb_parity, ce_count} !== '0) begin errors++; $display("FAIL rst_async_bus: got %h want 0", {wb_addr, wb_data, wb_parity, ce_count}); end
    tick();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (wb_req || busy) saw = 1'b1;
    end
    checks++; if (saw !== 1'b0) begin errors++; $display("FAIL rst_entries_lost: got %b want 0", saw); end
  endtask

  task automatic test_dedup;
    int n = 0;
    int want;
`ifdef SCRUB_DEDUP_EN
    want = 1;
`else
    want = 2;
`endif
    clear_status();
    wb_ack = 1'b0;
    drive(1, 10'h044, 32'h5, 6'h1, 1, 0);
    tick();
    tick();
    drive(0, '0, '0, '0, 0, 0);
    tick();
    tick();
    for (int i = 0; i < 20; i++) begin
      if (wb_req) begin
        n++;
        ack_one();
      end else begin
        tick();
      end
    end
    checks++; if (n != want) begin errors++; $display("FAIL dedup_wb_count: got %0d want %0d", n, want); end
    checks++; if (ce_count !== 16'd2 || fifo_ovf !== 1'b0) begin errors++; $display("FAIL dedup_ce_count: got %0d ovf %b want 2 0", ce_count, fifo_ovf); end
  endtask

  initial begin
    test_reset();
    test_ce_writeback();
    test_ue_capture();
    test_clr_priority();
    test_parity();
    test_overflow();
    test_reset_mid_req();
    test_dedup();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
